// File: rtl/system.sv
// UART echo top: sends a 4-byte "OK\r\n" banner after reset, then echoes every
// well-framed 8N1 byte received. The LED toggles once per accepted byte.
`timescale 1ns/1ps
module system #(
  parameter int clk_freq       = 50000000,
  parameter int uart_baud_rate = 115200
) (
  input  logic clk,
  input  logic rst,
  output logic led,
  input  logic uart_rxd,
  output logic uart_txd
);

  localparam int DIV   = clk_freq / uart_baud_rate;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV) + 1;
  localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_st_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_st_e;

  typedef struct packed {
    logic       vld;
    logic [7:0] data;
  } byte_req_t;

  // ---------------- RX ----------------
  logic [1:0]       sync_q, sync_d;
  rx_st_e           rx_st_q, rx_st_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rxs;

  assign rxs = sync_q[1];

  always_comb begin
    sync_d     = {sync_q[0], uart_rxd};
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_valid_d = 1'b0;
    case (rx_st_q)
      RX_IDLE: if (!rxs) begin
        rx_st_d  = RX_START;
        rx_cnt_d = '0;
      end
      RX_START: begin
        // Mid-start re-check rejects glitches shorter than half a bit.
        if (rx_cnt_q == HALF_M1) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_st_d  = rxs ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == DIV_M1) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rxs, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == DIV_M1) begin
          rx_cnt_d = '0;
          if (rxs) begin
            rx_valid_d = 1'b1;
            rx_st_d    = RX_IDLE;
          end else begin
            rx_st_d    = RX_BREAK;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_BREAK: if (rxs) rx_st_d = RX_IDLE;
      default:  rx_st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= 2'b11;
      rx_st_q    <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // ---------------- banner / buffer / load arbitration ----------------
  logic [2:0] ban_idx_q, ban_idx_d;
  logic [7:0] buf_q, buf_d;
  logic       buf_full_q, buf_full_d;
  logic       led_q, led_d;
  logic       banner_done, tx_free, load, taking_buf, bypass;
  logic [7:0] ban_byte;
  byte_req_t  src;

  tx_st_e           tx_st_q, tx_st_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_sh_q, tx_sh_d;
  logic             txd_q, txd_d;

  assign banner_done = (ban_idx_q == 3'd4);
  assign tx_free     = (tx_st_q == TX_IDLE) ||
                       ((tx_st_q == TX_STOP) && (tx_cnt_q == DIV_M1));

  always_comb begin
    ban_byte = 8'h4F;
    case (ban_idx_q[1:0])
      2'd0: ban_byte = 8'h4F;
      2'd1: ban_byte = 8'h4B;
      2'd2: ban_byte = 8'h0D;
      2'd3: ban_byte = 8'h0A;
      default: ban_byte = 8'h4F;
    endcase
  end

  // Banner first, then the held byte, else a fresh byte straight from RX
  // so an idle transmitter does not wait a cycle for the buffer write.
  always_comb begin
    src = '0;
    if (!banner_done)    src = '{vld: 1'b1, data: ban_byte};
    else if (buf_full_q) src = '{vld: 1'b1, data: buf_q};
    else if (rx_valid_q) src = '{vld: 1'b1, data: rx_sh_q};
    load       = tx_free && src.vld;
    taking_buf = load && banner_done && buf_full_q;
    bypass     = load && banner_done && !buf_full_q;
  end

  always_comb begin
    ban_idx_d  = ban_idx_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    led_d      = led_q ^ rx_valid_q;
    if (load && !banner_done) ban_idx_d = ban_idx_q + 1'b1;
    if (taking_buf) buf_full_d = 1'b0;
    // A byte arriving while the buffer is full and not draining is dropped.
    if (rx_valid_q && !bypass && (!buf_full_q || taking_buf)) begin
      buf_d      = rx_sh_q;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ban_idx_q  <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      led_q      <= 1'b0;
    end else begin
      ban_idx_q  <= ban_idx_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      led_q      <= led_d;
    end
  end

  // ---------------- TX ----------------
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    case (tx_st_q)
      TX_IDLE: if (load) begin
        tx_st_d  = TX_START;
        tx_cnt_d = '0;
        tx_bit_d = '0;
        tx_sh_d  = src.data;
      end
      TX_START: begin
        if (tx_cnt_q == DIV_M1) begin
          tx_cnt_d = '0;
          tx_st_d  = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == DIV_M1) begin
          tx_cnt_d = '0;
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          tx_bit_d = tx_bit_q + 1'b1;
          if (tx_bit_q == 3'd7) tx_st_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == DIV_M1) begin
          tx_cnt_d = '0;
          if (load) begin
            tx_st_d  = TX_START;
            tx_bit_d = '0;
            tx_sh_d  = src.data;
          end else begin
            tx_st_d  = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_st_d = TX_IDLE;
    endcase
  end

  // Line level follows the current state through a register, so the pin is
  // glitch-free and every bit lasts exactly DIV cycles.
  always_comb begin
    case (tx_st_q)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_sh_q[0];
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_st_q  <= TX_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      txd_q    <= 1'b1;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q  <= tx_sh_d;
      txd_q    <= txd_d;
    end
  end

  assign led      = led_q;
  assign uart_txd = txd_q;

endmodule

// File: tb/tb_system.sv
// Directed bench for the UART echo top: banner, echo, overrun, framing,
// false start and mid-frame reset, with a TX line decoder as reference.
`timescale 1ns/1ps
module tb_system;
  localparam int DIV = 50000000 / 1152000;

  logic clk = 1'b0;
  logic rst;
  logic led;
  logic rxd;
  logic txd;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  system #(.clk_freq(50000000), .uart_baud_rate(1152000)) dut (
    .clk      (clk),
    .rst      (rst),
    .led      (led),
    .uart_rxd (rxd),
    .uart_txd (txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // TX line decoder: samples mid-bit, records byte and start-edge cycle.
  logic [7:0] mon_q[$];
  int         mon_t[$];
  logic [7:0] msh;
  int         mbusy = 0, mcnt = 0, mbit = 0, mt = 0;
  int         start_errs = 0, stop_errs = 0;

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      mbusy = 0;
    end else if (mbusy == 0) begin
      if (txd === 1'b0) begin
        mbusy = 1; mcnt = 0; mbit = 0; mt = cyc;
      end
    end else begin
      mcnt++;
      if (mcnt == DIV/2 + mbit*DIV) begin
        if (mbit == 0) begin
          if (txd !== 1'b0) start_errs++;
        end else if (mbit <= 8) begin
          msh[mbit-1] = txd;
        end else begin
          if (txd !== 1'b1) stop_errs++;
          mon_q.push_back(msh);
          mon_t.push_back(mt);
          mbusy = 0;
        end
        mbit++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop);
    rxd = 1'b0; tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i]; tick(DIV);
    end
    rxd = stop; tick(DIV);
    rxd = 1'b1;
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (mon_q.size() < n && k < budget) begin
      tick(1); k++;
    end
    chk(tag, (mon_q.size() >= n), 1'b1);
  endtask

  task automatic chk_byte(input string tag, input int idx, input logic [7:0] exp);
    logic [31:0] got;
    got = (mon_q.size() > idx) ? {24'h0, mon_q[idx]} : 32'hFFFF_FFFF;
    chk(tag, got, {24'h0, exp});
  endtask

  task automatic chk_gap(input string tag, input int idx);
    logic [31:0] got;
    got = (mon_t.size() > idx) ? (mon_t[idx] - mon_t[idx-1]) : 32'hFFFF_FFFF;
    chk(tag, got, 10*DIV);
  endtask

  initial begin
    int base, k;
    rst = 1'b0;
    rxd = 1'b1;
    #20;
    chk("rst_txd", txd, 1'b1);
    chk("rst_led", led, 1'b0);
    #20;
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1 chk("edge1_txd", txd, 1'b1);
    @(posedge clk) #1 chk("edge2_txd", txd, 1'b0);

    // Two bytes during the banner: first buffered, second overruns.
    uart_send(8'h11, 1'b1);
    chk("led_after_11", led, 1'b1);
    uart_send(8'h22, 1'b1);
    chk("led_after_22", led, 1'b0);

    wait_bytes("banner_done", 5, 3000);
    chk_byte("ban0", 0, 8'h4F);
    chk_byte("ban1", 1, 8'h4B);
    chk_byte("ban2", 2, 8'h0D);
    chk_byte("ban3", 3, 8'h0A);
    chk_byte("echo_11", 4, 8'h11);
    chk_gap("gap1", 1);
    chk_gap("gap2", 2);
    chk_gap("gap3", 3);
    chk_gap("gap4", 4);

    tick(2000);
    chk("no_echo_22", mon_q.size(), 5);
    chk("idle_txd", txd, 1'b1);

    uart_send(8'hA5, 1'b1);
    chk("led_after_a5", led, 1'b1);
    wait_bytes("echo_a5_wait", 6, 1000);
    chk_byte("echo_a5", 5, 8'hA5);
    uart_send(8'h3C, 1'b1);
    chk("led_after_3c", led, 1'b0);
    wait_bytes("echo_3c_wait", 7, 1000);
    chk_byte("echo_3c", 6, 8'h3C);

    // Framing error then a short glitch: neither produces a byte.
    uart_send(8'h55, 1'b0);
    tick(1000);
    chk("ferr_count", mon_q.size(), 7);
    chk("ferr_led", led, 1'b0);
    rxd = 1'b0; tick(DIV/4); rxd = 1'b1;
    tick(500);
    chk("glitch_count", mon_q.size(), 7);
    chk("glitch_led", led, 1'b0);

    // A good byte proves RX is idle again; reset lands mid-echo.
    uart_send(8'h96, 1'b1);
    chk("led_after_96", led, 1'b1);
    k = 0;
    while (mbusy == 0 && k < 100) begin tick(1); k++; end
    chk("echo_96_started", mbusy, 1);
    tick(5*DIV);
    #2 rst = 1'b0;
    #1;
    chk("midrst_txd", txd, 1'b1);
    chk("midrst_led", led, 1'b0);
    base = mon_q.size();
    tick(4);
    @(negedge clk) rst = 1'b1;
    wait_bytes("rebanner_done", base + 4, 2500);
    chk_byte("reban0", base + 0, 8'h4F);
    chk_byte("reban1", base + 1, 8'h4B);
    chk_byte("reban2", base + 2, 8'h0D);
    chk_byte("reban3", base + 3, 8'h0A);
    tick(1000);
    chk("reban_no_extra", mon_q.size(), base + 4);
    chk("final_txd", txd, 1'b1);
    chk("start_errs", start_errs, 0);
    chk("stop_errs", stop_errs, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
